fake_n64_controller_tx: RTL

//  Reply serialiser downstream of the controller receive stage. Picks the response for a decoded command.

---
 rtl/fake_n64_pkg.sv | 34 +++
 rtl/n64_bit_encoder.sv | 42 ++++
 rtl/fake_n64_controller_tx.sv | 108 ++++++++++
 3 files changed

// File: rtl/fake_n64_pkg.sv
// Shared definitions for the fake N64 controller: command codes, reply lengths, FSM states.
package fake_n64_pkg;

    localparam logic [7:0] CMD_INFO   = 8'h00;
    localparam logic [7:0] CMD_STATUS = 8'h01;
    localparam logic [7:0] CMD_READ   = 8'h02;
    localparam logic [7:0] CMD_WRITE  = 8'h03;
    localparam logic [7:0] CMD_RESET  = 8'hFF;

    localparam int INFO_BITS   = 24;
    localparam int STATUS_BITS = 32;
    localparam int WRITE_BITS  = 8;

    localparam logic [1:0] ST_IDLE_ENC = 2'd0;
    localparam logic [1:0] ST_BIT_ENC  = 2'd1;
    localparam logic [1:0] ST_STOP_ENC = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = ST_IDLE_ENC,
        ST_BIT  = ST_BIT_ENC,
        ST_STOP = ST_STOP_ENC
    } tx_state_t;

    // Zero means the command has no reply (READ and anything unknown).
    function automatic logic [5:0] reply_bits(input logic [7:0] c);
        case (c)
            CMD_INFO, CMD_RESET: return 6'(INFO_BITS);
            CMD_STATUS:          return 6'(STATUS_BITS);
            CMD_WRITE:           return 6'(WRITE_BITS);
            default:             return 6'd0;
        endcase
    endfunction

endpackage

// File: rtl/n64_bit_encoder.sv
// Quarter-bit timing for N64 line coding; produces the raw (unregistered) line level
// for the current bit or stop bit and flags the last clock of each bit period.
module n64_bit_encoder #(
    parameter int QUARTER_CYCLES = 50
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic bit_val,
    input  logic is_stop,
    output logic line,
    output logic bit_done
);

    localparam int TW = (QUARTER_CYCLES > 1) ? $clog2(QUARTER_CYCLES) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(QUARTER_CYCLES - 1);

    logic [TW-1:0] timer;
    logic [1:0]    qidx;
    logic          quarter_end;
    logic [1:0]    low_quarters;

    assign quarter_end = (timer == T_LAST);
    assign bit_done    = quarter_end && (qidx == 2'd3);

    always_ff @(posedge clk) begin
        if (reset || start) begin
            timer <= '0;
            qidx  <= 2'd0;
        end else if (quarter_end) begin
            timer <= '0;
            qidx  <= qidx + 2'd1;
        end else begin
            timer <= timer + TW'(1);
        end
    end

    // Quarters held low at the start of the period: stop=2, one=1, zero=3.
    assign low_quarters = is_stop ? 2'd2 : (bit_val ? 2'd1 : 2'd3);
    assign line         = (qidx >= low_quarters);

endmodule

// File: rtl/fake_n64_controller_tx.sv
// Reply serialiser: latches the reply for a decoded command and shifts it out MSB first,
// followed by the controller stop bit, on the open-drain single-wire bus.
module fake_n64_controller_tx
    import fake_n64_pkg::*;
#(
    parameter int          QUARTER_CYCLES = 50,
    parameter logic [23:0] INFO_RESP      = 24'h050002
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tx_start,
    input  logic [7:0]  cmd,
    input  logic [7:0]  crc,
    input  logic [31:0] buttons,
    output logic        data_tx,
    output logic        busy,
    output logic        done
);

    tx_state_t   state, state_n;
    logic [31:0] shreg;
    logic [5:0]  bit_cnt;
    logic [5:0]  n_bits;
    logic [31:0] reply_word;
    logic        accept;
    logic        supported;
    logic        finish;
    logic        tail;
    logic        enc_line;
    logic        bit_done;
    logic        is_stop;

    assign n_bits    = reply_bits(cmd);
    assign supported = (n_bits != 6'd0);
    assign accept    = (state == ST_IDLE) && tx_start;
    assign is_stop   = (state == ST_STOP);

    // Reply is left-aligned so the MSB always sits at shreg[31].
    always_comb begin
        reply_word = {INFO_RESP, 8'h00};
        case (cmd)
            CMD_STATUS: reply_word = buttons;
            CMD_WRITE:  reply_word = {crc, 24'h000000};
            default:    reply_word = {INFO_RESP, 8'h00};
        endcase
    end

    n64_bit_encoder #(
        .QUARTER_CYCLES(QUARTER_CYCLES)
    ) u_enc (
        .clk      (clk),
        .reset    (reset),
        .start    (accept),
        .bit_val  (shreg[31]),
        .is_stop  (is_stop),
        .line     (enc_line),
        .bit_done (bit_done)
    );

    always_comb begin
        state_n = state;
        finish  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (tx_start && supported) state_n = ST_BIT;
                if (tx_start && !supported) finish = 1'b1;
            end
            ST_BIT: begin
                if (bit_done && bit_cnt == 6'd0) state_n = ST_STOP;
            end
            ST_STOP: begin
                if (bit_done) begin
                    state_n = ST_IDLE;
                    finish  = 1'b1;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // data_tx lags the encoder by one register, so done/busy trail the FSM by one
    // cycle (tail) to line up with the end of the last high quarter on the wire.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
            tail    <= 1'b0;
            done    <= 1'b0;
            busy    <= 1'b0;
            data_tx <= 1'b1;
        end else begin
            state   <= state_n;
            tail    <= finish;
            done    <= tail;
            busy    <= (state_n != ST_IDLE) || (is_stop && bit_done);
            data_tx <= (state == ST_BIT || state == ST_STOP) ? enc_line : 1'b1;
            if (accept && supported) begin
                shreg   <= reply_word;
                bit_cnt <= n_bits - 6'd1;
            end else if (state == ST_BIT && bit_done) begin
                shreg <= {shreg[30:0], 1'b0};
                if (bit_cnt != 6'd0) bit_cnt <= bit_cnt - 6'd1;
            end
        end
    end

endmodule
